// File: rtl/elevator_group_dispatcher.sv
// elevator_group_dispatcher
//   Latches hall calls into up/down pending registers. It scans them round-robin
//   from a fairness pointer and offers one call at a time to the nearest idle car.
//
// Ports
//   clk, reset            rising-edge clock; asynchronous active-high reset
//   hall_up_req           up-button requests, bit n = floor n
//   hall_down_req         down-button requests, bit n = floor n
//   car0_floor/car1_floor current floor of each car
//   car_idle[i]           car i can take an assignment
//   car_ack[i]            car i accepts the call currently offered to it
//   assign_valid[i]       call offered to car i (one-hot or zero)
//   assign_floor          floor of the offered call
//   assign_up             direction of the offered call, 1 = up
//   up_lamp/down_lamp     pending up/down calls
//   timeout_err           one-cycle pulse when an offer expires unacknowledged
//   fsm_state             dispatcher state, for observation only
//
// Handshake: assign_valid[i] stays high with assign_floor/assign_up stable until
// the cycle in which car_ack[i] is high (transfer on that rising edge). It also
// ends when car i drops car_idle, or when the offer times out. Acks from the car
// not being offered to have no effect.
module elevator_group_dispatcher #(
    parameter int NUM_FLOORS  = 4,
    parameter int FLOOR_BITS  = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] hall_up_req,
    input  logic [NUM_FLOORS-1:0] hall_down_req,
    input  logic [FLOOR_BITS-1:0] car0_floor,
    input  logic [FLOOR_BITS-1:0] car1_floor,
    input  logic [1:0]            car_idle,
    input  logic [1:0]            car_ack,
    output logic [1:0]            assign_valid,
    output logic [FLOOR_BITS-1:0] assign_floor,
    output logic                  assign_up,
    output logic [NUM_FLOORS-1:0] up_lamp,
    output logic [NUM_FLOORS-1:0] down_lamp,
    output logic                  timeout_err,
    output logic [1:0]            fsm_state
);
    localparam int SLOTS = 2 * NUM_FLOORS;
    localparam int PW    = FLOOR_BITS + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PICK  = 2'd1;
    localparam logic [1:0] S_OFFER = 2'd2;

    logic [1:0]            state;
    logic [PW-1:0]         ptr;
    logic [NUM_FLOORS-1:0] up_pend;
    logic [NUM_FLOORS-1:0] down_pend;
    logic [PW-1:0]         off_slot;
    logic                  off_car;
    logic [7:0]            cnt;

    // Slot vector: up calls in the low half, down calls in the high half.
    logic [SLOTS-1:0]      pend_vec;
    logic                  found;
    logic [PW-1:0]         pick_slot;
    logic [PW:0]           sum;
    logic [PW-1:0]         idx;
    logic [PW-1:0]         floor_wide;
    logic [FLOOR_BITS-1:0] pick_floor;
    logic                  pick_up;
    logic [FLOOR_BITS-1:0] d0;
    logic [FLOOR_BITS-1:0] d1;
    logic                  pick_car;
    logic [PW-1:0]         next_slot;
    logic                  ack_hit;
    logic                  chosen_idle;
    logic [SLOTS-1:0]      clr_vec;

    assign pend_vec = {down_pend, up_pend};

    // First pending slot at or after ptr, wrapping modulo SLOTS.
    always_comb begin
        found     = 1'b0;
        pick_slot = '0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < SLOTS; i++) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(SLOTS))
                sum = sum - (PW+1)'(SLOTS);
            idx = sum[PW-1:0];
            if (!found && pend_vec[idx]) begin
                found     = 1'b1;
                pick_slot = idx;
            end
        end
    end

    always_comb begin
        pick_up    = (pick_slot < PW'(NUM_FLOORS));
        floor_wide = pick_up ? pick_slot : (pick_slot - PW'(NUM_FLOORS));
        pick_floor = floor_wide[FLOOR_BITS-1:0];
        d0 = (car0_floor >= pick_floor) ? (car0_floor - pick_floor) : (pick_floor - car0_floor);
        d1 = (car1_floor >= pick_floor) ? (car1_floor - pick_floor) : (pick_floor - car1_floor);
        // Car 1 only when it is the sole idle car or strictly closer; ties go to car 0.
        if (car_idle == 2'b10)
            pick_car = 1'b1;
        else if (car_idle == 2'b01)
            pick_car = 1'b0;
        else
            pick_car = (d1 < d0);
    end

    assign next_slot   = (off_slot == PW'(SLOTS - 1)) ? '0 : off_slot + 1'b1;
    assign ack_hit     = (state == S_OFFER) && car_ack[off_car];
    assign chosen_idle = car_idle[off_car];
    // An accepted call is cleared even if its button is pressed again in the same cycle.
    assign clr_vec     = ack_hit ? (SLOTS'(1) << off_slot) : '0;

    assign assign_valid = (state != S_OFFER) ? 2'b00 : (off_car ? 2'b10 : 2'b01);
    assign up_lamp      = up_pend;
    assign down_lamp    = down_pend;
    assign fsm_state    = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            ptr          <= '0;
            up_pend      <= '0;
            down_pend    <= '0;
            off_slot     <= '0;
            off_car      <= 1'b0;
            assign_floor <= '0;
            assign_up    <= 1'b0;
            cnt          <= '0;
            timeout_err  <= 1'b0;
        end else begin
            up_pend     <= (up_pend | hall_up_req) & ~clr_vec[NUM_FLOORS-1:0];
            down_pend   <= (down_pend | hall_down_req) & ~clr_vec[SLOTS-1:NUM_FLOORS];
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if ((|pend_vec) && (|car_idle))
                        state <= S_PICK;
                end
                S_PICK: begin
                    if (found && (|car_idle)) begin
                        off_slot     <= pick_slot;
                        off_car      <= pick_car;
                        assign_floor <= pick_floor;
                        assign_up    <= pick_up;
                        cnt          <= '0;
                        state        <= S_OFFER;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_OFFER: begin
                    if (ack_hit) begin
                        ptr   <= next_slot;
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else if (!chosen_idle) begin
                        // Car went busy: withdraw quietly and leave the pointer alone.
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else if (cnt == 8'(ACK_TIMEOUT - 1)) begin
                        // Skip past the ignored call so the other calls still get served.
                        timeout_err <= 1'b1;
                        ptr         <= next_slot;
                        cnt         <= '0;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_elevator_group_dispatcher.sv
// tb_elevator_group_dispatcher
//   Directed scenarios for each dispatcher feature, then randomized call traffic
//   checked against a transaction-level model. The model tracks pending calls and
//   the scan pointer, and works out the expected offer from the dispatch rules.
module tb_elevator_group_dispatcher;
    localparam int NF = 4;
    localparam int FB = 2;
    localparam int TO = 16;
    localparam int NS = 2 * NF;

    logic          clk = 1'b0;
    logic          reset;
    logic [NF-1:0] hall_up_req;
    logic [NF-1:0] hall_down_req;
    logic [FB-1:0] car0_floor;
    logic [FB-1:0] car1_floor;
    logic [1:0]    car_idle;
    logic [1:0]    car_ack;
    logic [1:0]    assign_valid;
    logic [FB-1:0] assign_floor;
    logic          assign_up;
    logic [NF-1:0] up_lamp;
    logic [NF-1:0] down_lamp;
    logic          timeout_err;
    logic [1:0]    fsm_state;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state and scoreboard of expected offers {car, up, floor}.
    logic [NF-1:0] m_up;
    logic [NF-1:0] m_dn;
    int            m_ptr;
    logic [4:0]    exp_q[$];

    elevator_group_dispatcher #(.NUM_FLOORS(NF), .FLOOR_BITS(FB), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .hall_up_req(hall_up_req), .hall_down_req(hall_down_req),
        .car0_floor(car0_floor), .car1_floor(car1_floor),
        .car_idle(car_idle), .car_ack(car_ack),
        .assign_valid(assign_valid), .assign_floor(assign_floor), .assign_up(assign_up),
        .up_lamp(up_lamp), .down_lamp(down_lamp),
        .timeout_err(timeout_err), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse(input logic [NF-1:0] up, input logic [NF-1:0] dn);
        hall_up_req   = up;
        hall_down_req = dn;
        tick();
        hall_up_req   = '0;
        hall_down_req = '0;
    endtask

    task automatic wait_offer(input string name, output int cyc);
        cyc = 0;
        while (assign_valid == 2'b00 && cyc < 40) begin
            tick();
            cyc++;
        end
        n_cmp++;
        if (assign_valid === 2'b00) begin
            n_fail++;
            $display("FAIL %s_wait: no offer within %0d cycles (required: offer)", name, cyc);
        end
    endtask

    task automatic ack_car(input logic [1:0] which);
        car_ack = which;
        tick();
        car_ack = 2'b00;
    endtask

    // ---------------- reference model ----------------
    function automatic int first_slot(input logic [NF-1:0] up, input logic [NF-1:0] dn, input int p);
        logic [NS-1:0] v;
        v = {dn, up};
        for (int k = 0; k < NS; k++) begin
            int s;
            s = (p + k) % NS;
            if (v[s]) return s;
        end
        return -1;
    endfunction

    function automatic logic [1:0] expect_car(input int fl, input int c0, input int c1, input logic [1:0] idle);
        int a0;
        int a1;
        a0 = (c0 > fl) ? c0 - fl : fl - c0;
        a1 = (c1 > fl) ? c1 - fl : fl - c1;
        if (idle == 2'b10) return 2'b10;
        if (idle == 2'b01) return 2'b01;
        return (a1 < a0) ? 2'b10 : 2'b01;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        n_cmp++; if (assign_valid !== 2'b00) begin n_fail++; $display("FAIL rst_valid: got %b required 00", assign_valid); end
        n_cmp++; if (assign_floor !== 2'd0) begin n_fail++; $display("FAIL rst_floor: got %0d required 0", assign_floor); end
        n_cmp++; if (assign_up !== 1'b0) begin n_fail++; $display("FAIL rst_up: got %b required 0", assign_up); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b required 0", timeout_err); end
        // Buttons held during reset must not light lamps.
        hall_up_req   = '1;
        hall_down_req = '1;
        tick();
        n_cmp++; if (up_lamp !== 4'b0000 || down_lamp !== 4'b0000) begin
            n_fail++; $display("FAIL rst_lamps: got up=%b down=%b required 0000/0000", up_lamp, down_lamp); end
        hall_up_req   = '0;
        hall_down_req = '0;
        reset = 1'b0;
        tick();
        n_cmp++; if (assign_valid !== 2'b00) begin n_fail++; $display("FAIL rst_release_valid: got %b required 00", assign_valid); end
    endtask

    task automatic test_basic();
        car0_floor = 2'd0; car1_floor = 2'd3; car_idle = 2'b11;
        pulse(4'b0100, 4'b0000);
        n_cmp++; if (up_lamp !== 4'b0100) begin n_fail++; $display("FAIL basic_lamp_set: got %b required 0100", up_lamp); end
        n_cmp++; if (assign_valid !== 2'b00) begin n_fail++; $display("FAIL basic_lat1: got %b required 00", assign_valid); end
        tick();
        n_cmp++; if (assign_valid !== 2'b00) begin n_fail++; $display("FAIL basic_lat2: got %b required 00", assign_valid); end
        tick();
        n_cmp++; if ({assign_valid, assign_up, assign_floor} !== {2'b10, 1'b1, 2'd2}) begin
            n_fail++; $display("FAIL basic_offer: got valid=%b up=%b floor=%0d required 10/1/2", assign_valid, assign_up, assign_floor); end
        ack_car(2'b10);
        n_cmp++; if (up_lamp !== 4'b0000 || assign_valid !== 2'b00) begin
            n_fail++; $display("FAIL basic_ack: got lamp=%b valid=%b required 0000/00", up_lamp, assign_valid); end
    endtask

    task automatic test_tie_and_foreign_ack();
        int cyc;
        car0_floor = 2'd1; car1_floor = 2'd1; car_idle = 2'b11;
        pulse(4'b0000, 4'b0010);
        wait_offer("tie", cyc);
        n_cmp++; if ({assign_valid, assign_up, assign_floor} !== {2'b01, 1'b0, 2'd1}) begin
            n_fail++; $display("FAIL tie_offer: got valid=%b up=%b floor=%0d required 01/0/1", assign_valid, assign_up, assign_floor); end
        ack_car(2'b10);
        n_cmp++; if (assign_valid !== 2'b01 || down_lamp !== 4'b0010) begin
            n_fail++; $display("FAIL foreign_ack: got valid=%b lamp=%b required 01/0010", assign_valid, down_lamp); end
        ack_car(2'b01);
        n_cmp++; if (down_lamp !== 4'b0000) begin n_fail++; $display("FAIL tie_clear: got %b required 0000", down_lamp); end
    endtask

    task automatic test_scan_order();
        int cyc;
        do_reset();
        car0_floor = 2'd0; car1_floor = 2'd0; car_idle = 2'b11;
        pulse(4'b1000, 4'b0001);
        wait_offer("scan1", cyc);
        n_cmp++; if ({assign_valid, assign_up, assign_floor} !== {2'b01, 1'b1, 2'd3}) begin
            n_fail++; $display("FAIL scan_first: got valid=%b up=%b floor=%0d required 01/1/3", assign_valid, assign_up, assign_floor); end
        ack_car(2'b01);
        wait_offer("scan2", cyc);
        n_cmp++; if (cyc !== 2) begin n_fail++; $display("FAIL scan_latency: got %0d required 2", cyc); end
        n_cmp++; if ({assign_valid, assign_up, assign_floor} !== {2'b01, 1'b0, 2'd0}) begin
            n_fail++; $display("FAIL scan_second: got valid=%b up=%b floor=%0d required 01/0/0", assign_valid, assign_up, assign_floor); end
        ack_car(2'b01);
        n_cmp++; if (up_lamp !== 4'b0000 || down_lamp !== 4'b0000) begin
            n_fail++; $display("FAIL scan_lamps: got %b/%b required 0000/0000", up_lamp, down_lamp); end
    endtask

    // Pointer sits at slot 5 here; slot 7 (down 3) is ahead of slot 1 (up 1).
    task automatic test_timeout();
        int cyc;
        int n;
        car0_floor = 2'd0; car1_floor = 2'd3; car_idle = 2'b11;
        pulse(4'b0010, 4'b1000);
        wait_offer("to1", cyc);
        n_cmp++; if ({assign_valid, assign_up, assign_floor} !== {2'b10, 1'b0, 2'd3}) begin
            n_fail++; $display("FAIL to_offer: got valid=%b up=%b floor=%0d required 10/0/3", assign_valid, assign_up, assign_floor); end
        n = 0;
        while (assign_valid != 2'b00 && n < 40) begin
            n++;
            tick();
        end
        n_cmp++; if (n !== TO) begin n_fail++; $display("FAIL to_length: got %0d cycles required %0d", n, TO); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_pulse: got %b required 1", timeout_err); end
        n_cmp++; if (down_lamp !== 4'b1000) begin n_fail++; $display("FAIL to_lamp: got %b required 1000", down_lamp); end
        tick();
        n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_one_cycle: got %b required 0", timeout_err); end
        wait_offer("to2", cyc);
        n_cmp++; if ({assign_valid, assign_up, assign_floor} !== {2'b01, 1'b1, 2'd1}) begin
            n_fail++; $display("FAIL to_advance: got valid=%b up=%b floor=%0d required 01/1/1", assign_valid, assign_up, assign_floor); end
        ack_car(2'b01);
        wait_offer("to3", cyc);
        n_cmp++; if ({assign_valid, assign_up, assign_floor} !== {2'b10, 1'b0, 2'd3}) begin
            n_fail++; $display("FAIL to_reoffer: got valid=%b up=%b floor=%0d required 10/0/3", assign_valid, assign_up, assign_floor); end
        ack_car(2'b10);
    endtask

    task automatic test_withdraw_and_no_idle();
        int cyc;
        logic bad;
        car0_floor = 2'd2; car1_floor = 2'd2; car_idle = 2'b11;
        pulse(4'b0001, 4'b0000);
        wait_offer("wd", cyc);
        car_idle = 2'b00;
        tick();
        n_cmp++; if (assign_valid !== 2'b00 || timeout_err !== 1'b0 || up_lamp !== 4'b0001) begin
            n_fail++; $display("FAIL withdraw: got valid=%b to=%b lamp=%b required 00/0/0001", assign_valid, timeout_err, up_lamp); end
        bad = 1'b0;
        repeat (6) begin
            tick();
            if (assign_valid !== 2'b00 || up_lamp !== 4'b0001) bad = 1'b1;
        end
        n_cmp++; if (bad !== 1'b0) begin n_fail++; $display("FAIL no_idle_hold: got offer or lamp change while no car idle, required none"); end
        n_cmp++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL no_idle_state: got %0d required idle", fsm_state); end
        car_idle = 2'b10;
        wait_offer("wd2", cyc);
        n_cmp++; if ({cyc[1:0], assign_valid, assign_up, assign_floor} !== {2'd2, 2'b10, 1'b1, 2'd0}) begin
            n_fail++; $display("FAIL withdraw_reoffer: got lat=%0d valid=%b up=%b floor=%0d required 2/10/1/0", cyc, assign_valid, assign_up, assign_floor); end
        ack_car(2'b10);
        car_idle = 2'b11;
    endtask

    task automatic test_clear_wins();
        int cyc;
        car0_floor = 2'd0; car1_floor = 2'd0;
        pulse(4'b0000, 4'b0100);
        wait_offer("cw", cyc);
        hall_down_req = 4'b0100;
        ack_car(2'b01);
        hall_down_req = 4'b0000;
        n_cmp++; if (down_lamp !== 4'b0000) begin n_fail++; $display("FAIL clear_wins: got %b required 0000", down_lamp); end
        tick(); tick(); tick();
        n_cmp++; if (assign_valid !== 2'b00) begin n_fail++; $display("FAIL clear_no_reoffer: got %b required 00", assign_valid); end
    endtask

    task automatic test_reset_mid_offer();
        int cyc;
        logic bad;
        pulse(4'b0011, 4'b0100);
        wait_offer("rmo", cyc);
        reset = 1'b1;
        #1;
        n_cmp++; if (assign_valid !== 2'b00 || up_lamp !== 4'b0000 || down_lamp !== 4'b0000) begin
            n_fail++; $display("FAIL async_reset: got valid=%b up=%b down=%b required 00/0000/0000", assign_valid, up_lamp, down_lamp); end
        n_cmp++; if (assign_floor !== 2'd0 || assign_up !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_floor: got floor=%0d up=%b required 0/0", assign_floor, assign_up); end
        tick();
        reset = 1'b0;
        bad = 1'b0;
        repeat (6) begin
            tick();
            if (assign_valid !== 2'b00) bad = 1'b1;
        end
        n_cmp++; if (bad !== 1'b0) begin n_fail++; $display("FAIL post_reset_quiet: got an offer, required none"); end
    endtask

    task automatic test_random();
        int cyc;
        int slot;
        int n;
        int w;
        logic [1:0] ecar;
        logic [4:0] exp_w;
        logic [NF-1:0] nu;
        logic [NF-1:0] nd;
        logic [NS-1:0] sb;
        do_reset();
        m_up = '0; m_dn = '0; m_ptr = 0;
        for (int it = 0; it < 40; it++) begin
            if (m_up == '0 && m_dn == '0) begin
                car0_floor = FB'($urandom_range(0, NF - 1));
                car1_floor = FB'($urandom_range(0, NF - 1));
                car_idle   = 2'($urandom_range(1, 3));
                nu = NF'($urandom_range(0, 15));
                nd = NF'($urandom_range(1, 15));
                pulse(nu, nd);
                m_up = m_up | nu;
                m_dn = m_dn | nd;
            end
            slot = first_slot(m_up, m_dn, m_ptr);
            ecar = expect_car(slot % NF, int'(car0_floor), int'(car1_floor), car_idle);
            exp_q.push_back({ecar, (slot < NF) ? 1'b1 : 1'b0, FB'(slot % NF)});
            wait_offer("rnd", cyc);
            n_cmp++; if (cyc !== 2) begin n_fail++; $display("FAIL rnd_latency it%0d: got %0d required 2", it, cyc); end
            exp_w = exp_q.pop_front();
            n_cmp++; if ({assign_valid, assign_up, assign_floor} !== exp_w) begin
                n_fail++; $display("FAIL rnd_offer it%0d: got %b required %b", it, {assign_valid, assign_up, assign_floor}, exp_w); end
            n_cmp++; if (up_lamp !== m_up || down_lamp !== m_dn) begin
                n_fail++; $display("FAIL rnd_lamps it%0d: got %b/%b required %b/%b", it, up_lamp, down_lamp, m_up, m_dn); end
            sb = NS'(1) << slot;
            if ($urandom_range(0, 9) < 8) begin
                w = $urandom_range(0, 3);
                repeat (w) tick();
                n_cmp++; if ({assign_valid, assign_up, assign_floor} !== exp_w) begin
                    n_fail++; $display("FAIL rnd_hold it%0d: got %b required %b", it, {assign_valid, assign_up, assign_floor}, exp_w); end
                nu = ($urandom_range(0, 1) == 1) ? NF'($urandom_range(0, 15)) : '0;
                nd = ($urandom_range(0, 1) == 1) ? NF'($urandom_range(0, 15)) : '0;
                hall_up_req = nu; hall_down_req = nd;
                car_ack = ecar;
                tick();
                car_ack = 2'b00; hall_up_req = '0; hall_down_req = '0;
                m_up  = (m_up | nu) & ~sb[NF-1:0];
                m_dn  = (m_dn | nd) & ~sb[NS-1:NF];
                m_ptr = (slot + 1) % NS;
                n_cmp++; if (assign_valid !== 2'b00 || timeout_err !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_after_ack it%0d: got valid=%b to=%b required 00/0", it, assign_valid, timeout_err); end
                // New car positions take effect for the next pick.
                car0_floor = FB'($urandom_range(0, NF - 1));
                car1_floor = FB'($urandom_range(0, NF - 1));
                car_idle   = 2'($urandom_range(1, 3));
            end else begin
                n = 0;
                while (assign_valid != 2'b00 && n < 40) begin
                    n++;
                    tick();
                end
                m_ptr = (slot + 1) % NS;
                n_cmp++; if (n !== TO || timeout_err !== 1'b1) begin
                    n_fail++; $display("FAIL rnd_timeout it%0d: got %0d cycles to=%b required %0d/1", it, n, timeout_err, TO); end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset         = 1'b1;
        hall_up_req   = '0;
        hall_down_req = '0;
        car0_floor    = '0;
        car1_floor    = '0;
        car_idle      = 2'b00;
        car_ack       = 2'b00;
        test_reset();
        test_basic();
        test_tie_and_foreign_ack();
        test_scan_order();
        test_timeout();
        test_withdraw_and_no_idle();
        test_clear_wins();
        test_reset_mid_offer();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/elevator_group_dispatcher.md
ELEVATOR_GROUP_DISPATCHER -- requirements
Module: elevator_group_dispatcher

Interface
REQ-001 Parameter NUM_FLOORS, default 4, number of served floors.
REQ-002 Parameter FLOOR_BITS, default 2, floor index width, ceil(log2(NUM_FLOORS)).
REQ-003 Parameter ACK_TIMEOUT, default 16, max OFFER cycles awaiting car acknowledge; range 1..255.
REQ-004 clk  input  1  clock; all state rising-edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 hall_up_req  input  NUM_FLOORS  hall up-button pulses/levels, bit n = floor n.
REQ-007 hall_down_req  input  NUM_FLOORS  hall down-button pulses/levels, bit n = floor n.
REQ-008 car0_floor, car1_floor  input  FLOOR_BITS each  current floor of car 0 / car 1.
REQ-009 car_idle  input  2  bit i high = car i can accept an assignment.
REQ-010 car_ack  input  2  bit i high = car i accepts the offered call this cycle.
REQ-011 assign_valid  output  2  bit i high = call offered to car i; at most one bit set.
REQ-012 assign_floor  output  FLOOR_BITS  floor of offered call.
REQ-013 assign_up  output  1  direction of offered call, 1 = up.
REQ-014 up_lamp, down_lamp  output  NUM_FLOORS each  registered copy of pending up/down calls.
REQ-015 timeout_err  output  1  one-cycle pulse on offer timeout.

Function
REQ-016 Pending registers up_pend/down_pend SHALL OR in hall_up_req/hall_down_req every cycle; lamps equal pending registers.
REQ-017 Call slots SHALL be indexed 0..2*NUM_FLOORS-1: slot n = up call floor n, slot NUM_FLOORS+n = down call floor n; scan pointer ptr has FLOOR_BITS+1 bits.
REQ-018 FSM states SHALL be IDLE, PICK, OFFER.
REQ-019 IDLE -> PICK when any pending bit set and car_idle != 0; otherwise remain IDLE.
REQ-020 PICK (one cycle) SHALL latch the first pending slot at or after ptr, wrapping modulo 2*NUM_FLOORS, plus its floor and direction.
REQ-021 PICK SHALL choose, among cars with car_idle set, the smallest absolute floor distance to the call floor; tie or both equal -> car 0; then go to OFFER.
REQ-022 If car_idle becomes 0 or the slot is no longer pending at PICK, return to IDLE without offering.
REQ-023 OFFER SHALL drive assign_valid for the chosen car with assign_floor/assign_up held stable until exit.
REQ-024 OFFER with car_ack of chosen car high: clear that pending bit, set ptr = slot+1 mod 2*NUM_FLOORS, go IDLE; assign_valid low from next cycle.
REQ-025 car_ack bits of the non-chosen car SHALL be ignored.
REQ-026 OFFER with chosen car's car_idle low and no ack: withdraw, go IDLE, slot stays pending, ptr unchanged, no timeout_err.
REQ-027 OFFER counter SHALL count cycles from entry; at ACK_TIMEOUT cycles without ack: withdraw, pulse timeout_err, slot stays pending, ptr = slot+1 (fairness), go IDLE.
REQ-028 Same-cycle new hall request and ack-clear of that slot: clear wins (car already en route).
REQ-029 Decision latency from pending set (idle car available, FSM in IDLE) to assign_valid high SHALL be 2 cycles.

Reset
REQ-030 Reset SHALL force IDLE, ptr = 0, pending/lamps = 0, assign_valid = 0, assign_floor = 0, assign_up = 0, timeout_err = 0, counter = 0, immediately and independent of clk, including mid-OFFER.

Verification
REQ-031 Floor 2 up pulse, car0 at 0, car1 at 3, both idle -> 2 cycles later assign_valid=2'b10, assign_floor=2, assign_up=1; ack -> up_lamp[2]=0.
REQ-032 Car0 and car1 both at floor 1, call floor 1 down -> assign_valid=2'b01 (tie to car 0).
REQ-033 Pending up floor 3 and down floor 0, ptr=0 -> slot 3 offered first, after ack slot 4 (down floor 0) offered next.
REQ-034 No ack for ACK_TIMEOUT=16 cycles -> timeout_err one cycle, assign_valid=0, lamp stays set, ptr advances, next pending slot offered.
REQ-035 Reset asserted during OFFER -> assign_valid=0 and lamps=0 without a clock edge; after release no offer until new request.
REQ-036 car_idle=2'b00 with pending calls -> FSM stays IDLE, assign_valid=0, lamps hold.
